// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, flag bit positions, FSM states.
// No logic; imported by alu_arith and alu_seq.
// No handshake; constants only.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_ADC   = 3'd2,
        OP_SBC   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_XOR   = 3'd6,
        OP_SHIFT = 3'd7
    } op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_arith.sv
// Combinational add/sub/logic datapath with carry and overflow; SHIFT passes a through.
// Zero latency.
// No backpressure; pure function of its inputs.
module alu_arith
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_r,
    output logic             o_c,
    output logic             o_v
);

    logic [WIDTH-1:0] w_b_eff;
    logic             w_carry;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_b_eff = i_b;
        w_carry = 1'b0;
        case (op_e'(i_op))
            OP_SUB: begin w_b_eff = ~i_b; w_carry = 1'b1;  end
            OP_ADC: begin                 w_carry = i_cin; end
            OP_SBC: begin w_b_eff = ~i_b; w_carry = i_cin; end
            default: ;
        endcase
        w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_carry};

        o_r = i_a;
        o_c = 1'b0;
        o_v = 1'b0;
        case (op_e'(i_op))
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                o_r = w_sum[WIDTH-1:0];
                o_c = w_sum[WIDTH];
                // Signed overflow: operands agree in sign but the result does not.
                o_v = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_r = i_a & i_b;
            OP_OR:  o_r = i_a | i_b;
            OP_XOR: o_r = i_a ^ i_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered result, C/Z/N/V flag register, start/done handshake, gated bus drive.
// Latency: 1 cycle for non-shift ops; max(n,1) cycles for SHIFT by n.
// Backpressure: busy_o high during a multi-cycle shift; start_i is dropped while busy.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    input  logic             flag_we_i,
    input  logic             out_en_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] bus_o,
    output logic [3:0]       flags_o
);

    state_e             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_result, w_res_nxt;
    logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
    logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_flag_we, w_fwe_nxt;
    logic               r_done;
    logic [3:0]         r_flags, w_flags_nxt;
    logic               w_complete, w_c_nxt, w_v_nxt;

    logic [WIDTH-1:0]   w_ar_r;
    logic               w_ar_c, w_ar_v;
    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0]   w_sh_src, w_sh_step;
    logic               w_sh_dir, w_sh_out;

    alu_arith #(.WIDTH(WIDTH)) u_arith (
        .i_a   (a_i),
        .i_b   (b_i),
        .i_op  (op_i),
        .i_cin (r_flags[FLAG_C]),
        .o_r   (w_ar_r),
        .o_c   (w_ar_c),
        .o_v   (w_ar_v)
    );

    // The accept edge performs the first shift step, so a shift by n ends after n edges.
    assign w_amt     = b_i[SHAMT_W-1:0];
    assign w_sh_src  = (r_state == S_SHIFT) ? r_shreg : a_i;
    assign w_sh_dir  = (r_state == S_SHIFT) ? r_dir   : b_i[WIDTH-1];
    assign w_sh_step = w_sh_dir ? {w_sh_src[WIDTH-2:0], 1'b0} : {1'b0, w_sh_src[WIDTH-1:1]};
    assign w_sh_out  = w_sh_dir ? w_sh_src[WIDTH-1] : w_sh_src[0];

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_fwe_nxt   = r_flag_we;
        w_complete  = 1'b0;
        w_res_nxt   = r_result;
        w_c_nxt     = 1'b0;
        w_v_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_fwe_nxt = flag_we_i;
                    if (op_i != OP_SHIFT) begin
                        w_complete = 1'b1;
                        w_res_nxt  = w_ar_r;
                        w_c_nxt    = w_ar_c;
                        w_v_nxt    = w_ar_v;
                    end else if (w_amt == '0) begin
                        w_complete = 1'b1;
                        w_res_nxt  = a_i;
                    end else if (w_amt == SHAMT_W'(1)) begin
                        w_complete = 1'b1;
                        w_res_nxt  = w_sh_step;
                        w_c_nxt    = w_sh_out;
                    end else begin
                        w_state_nxt = S_SHIFT;
                        w_shreg_nxt = w_sh_step;
                        w_cnt_nxt   = w_amt - SHAMT_W'(1);
                        w_dir_nxt   = b_i[WIDTH-1];
                    end
                end
            end
            S_SHIFT: begin
                w_shreg_nxt = w_sh_step;
                w_cnt_nxt   = r_cnt - SHAMT_W'(1);
                if (r_cnt == SHAMT_W'(1)) begin
                    w_complete  = 1'b1;
                    w_res_nxt   = w_sh_step;
                    w_c_nxt     = w_sh_out;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase

        w_flags_nxt         = r_flags;
        w_flags_nxt[FLAG_C] = w_c_nxt;
        w_flags_nxt[FLAG_Z] = (w_res_nxt == '0);
        w_flags_nxt[FLAG_N] = w_res_nxt[WIDTH-1];
        w_flags_nxt[FLAG_V] = w_v_nxt;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_flag_we <= 1'b0;
            r_done    <= 1'b0;
            r_flags   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_result  <= w_res_nxt;
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
            r_flag_we <= w_fwe_nxt;
            r_done    <= w_complete;
            if (w_complete && w_fwe_nxt) begin
                r_flags <= w_flags_nxt;
            end
        end
    end

    assign busy_o  = (r_state == S_SHIFT);
    assign done_o  = r_done;
    assign bus_o   = out_en_i ? r_result : '0;
    assign flags_o = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table of single-cycle ops, then shift, abort and bus-gating sequences.
module tb_alu_seq;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [7:0] a_i, b_i;
    logic [2:0] op_i;
    logic       start_i, flag_we_i, out_en_i;
    logic       busy_o, done_o;
    logic [7:0] bus_o;
    logic [3:0] flags_o;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .op_i      (op_i),
        .start_i   (start_i),
        .flag_we_i (flag_we_i),
        .out_en_i  (out_en_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .bus_o     (bus_o),
        .flags_o   (flags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fwe;
        logic       oen;
        logic [7:0] bus;
        logic [3:0] flags;   // {C,Z,N,V}
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one start for a single edge; returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic fwe, input logic oen);
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; flag_we_i = fwe; out_en_i = oen; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b1, 1'b1, 8'h80, 4'b0011}; // ADD overflow
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 4'b1100}; // SUB equal
        vecs[2]  = '{3'd0, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h00, 4'b1100}; // ADD carry out
        vecs[3]  = '{3'd2, 8'h10, 8'h20, 1'b1, 1'b1, 8'h31, 4'b0000}; // ADC with C=1
        vecs[4]  = '{3'd3, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 4'b1000}; // SBC with C=0
        vecs[5]  = '{3'd4, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 4'b0000}; // AND
        vecs[6]  = '{3'd5, 8'h80, 8'h01, 1'b1, 1'b1, 8'h81, 4'b0010}; // OR
        vecs[7]  = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 4'b0010}; // SUB borrow
        vecs[8]  = '{3'd3, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 4'b1001}; // SBC C=0, overflow
        vecs[9]  = '{3'd2, 8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 4'b0011}; // ADC C=1, overflow
        vecs[10] = '{3'd6, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0011}; // XOR, flags held, bus off
        vecs[11] = '{3'd7, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, 4'b0000}; // SHIFT n=0
        vecs[12] = '{3'd7, 8'h03, 8'h01, 1'b1, 1'b1, 8'h01, 4'b1000}; // SHIFT right n=1

        rstn_i = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; op_i = '0;
        flag_we_i = 1'b0; out_en_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy",  busy_o,  0);
        chk("rst_done",  done_o,  0);
        chk("rst_bus",   bus_o,   0);
        chk("rst_flags", flags_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fwe, vecs[i].oen);
            chk($sformatf("v%0d_done", i),  done_o,  1);
            chk($sformatf("v%0d_busy", i),  busy_o,  0);
            chk($sformatf("v%0d_bus", i),   bus_o,   vecs[i].bus);
            chk($sformatf("v%0d_flags", i), flags_o, vecs[i].flags);
        end

        // Idle cycle: done drops; bus gating follows out_en with result 0x01 held.
        @(posedge clk_i); #1;
        chk("idle_done", done_o, 0);
        out_en_i = 1'b0; #1;
        chk("gate_off_bus", bus_o, 8'h00);
        out_en_i = 1'b1; #1;
        chk("gate_on_bus", bus_o, 8'h01);

        // XOR with flag_we=0/out_en=0, then raising out_en shows the zero result.
        issue(3'd6, 8'hAA, 8'hAA, 1'b0, 1'b0);
        chk("xor_bus_off", bus_o, 8'h00);
        chk("xor_flags",   flags_o, 4'b1000);
        out_en_i = 1'b1; #1;
        chk("xor_bus_on",  bus_o, 8'h00);

        // SHIFT left by 3 with an ADD attempted mid-shift.
        issue(3'd7, 8'h81, 8'h83, 1'b1, 1'b1);
        chk("shl_busy1", busy_o, 1);
        chk("shl_done1", done_o, 0);
        @(negedge clk_i);
        op_i = 3'd0; a_i = 8'h01; b_i = 8'h01; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("shl_busy2", busy_o, 1);
        chk("shl_done2", done_o, 0);
        @(posedge clk_i); #1;
        chk("shl_done3",  done_o,  1);
        chk("shl_busy3",  busy_o,  0);
        chk("shl_bus",    bus_o,   8'h08);
        chk("shl_flags",  flags_o, 4'b0000);
        @(posedge clk_i); #1;
        chk("shl_no_add_done", done_o, 0);
        chk("shl_no_add_bus",  bus_o,  8'h08);

        // SHIFT right by 2: both bits out are 1, so C ends at 1.
        issue(3'd7, 8'h0F, 8'h02, 1'b1, 1'b1);
        chk("shr_busy1", busy_o, 1);
        @(posedge clk_i); #1;
        chk("shr_done",  done_o,  1);
        chk("shr_bus",   bus_o,   8'h03);
        chk("shr_flags", flags_o, 4'b1000);

        // Asynchronous reset in the middle of a long shift.
        issue(3'd7, 8'hFF, 8'h87, 1'b1, 1'b1);
        chk("abort_busy_pre", busy_o, 1);
        #3;
        rstn_i = 1'b0;
        #1;
        chk("abort_busy",  busy_o,  0);
        chk("abort_done",  done_o,  0);
        chk("abort_bus",   bus_o,   0);
        chk("abort_flags", flags_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        issue(3'd0, 8'hFF, 8'h02, 1'b1, 1'b1);
        chk("post_done",  done_o,  1);
        chk("post_bus",   bus_o,   8'h01);
        chk("post_flags", flags_o, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
